// File: rtl/cpu_step_pkg.sv
// Shared types and widths for the CPU step/run controller.
package cpu_step_pkg;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_STEP     = 2'b01,
    ST_WAIT_REL = 2'b10,
    ST_RUN      = 2'b11
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // a return to the current level is the only possible change for 1 bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step/run clock-enable controller with rotary register selector.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int RUN_DIV   = 1
) (
  input  logic              CCLK,
  input  logic              RSTN,
  input  logic              sw_run,
  input  logic              btn_step,
  input  logic              rot_a,
  input  logic              rot_b,
  input  logic              rot_ctr,
  input  logic              cpu_halt,
  output logic              cpu_en,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [CNT_W-1:0]  step_cnt,
  output logic [1:0]        state_o
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  logic run_db;
  logic step_db;
  logic a_db;
  logic b_db;
  logic ctr_db;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run (
    .clk(CCLK), .rst_n(RSTN), .raw(sw_run), .level(run_db)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step (
    .clk(CCLK), .rst_n(RSTN), .raw(btn_step), .level(step_db)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rot_a (
    .clk(CCLK), .rst_n(RSTN), .raw(rot_a), .level(a_db)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rot_b (
    .clk(CCLK), .rst_n(RSTN), .raw(rot_b), .level(b_db)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rot_ctr (
    .clk(CCLK), .rst_n(RSTN), .raw(rot_ctr), .level(ctr_db)
  );

  logic step_prev;
  logic a_prev;
  logic ctr_prev;
  logic step_rise;
  logic a_rise;
  logic ctr_rise;

  // registered one-cycle rise pulses
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      step_prev <= 1'b0;
      a_prev    <= 1'b0;
      ctr_prev  <= 1'b0;
      step_rise <= 1'b0;
      a_rise    <= 1'b0;
      ctr_rise  <= 1'b0;
    end else begin
      step_prev <= step_db;
      a_prev    <= a_db;
      ctr_prev  <= ctr_db;
      step_rise <= step_db & ~step_prev;
      a_rise    <= a_db & ~a_prev;
      ctr_rise  <= ctr_db & ~ctr_prev;
    end
  end

  state_t        state;
  state_t        state_n;
  logic          en_n;
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;

  always_comb begin
    state_n = state;
    en_n    = 1'b0;
    div_n   = div;
    unique case (state)
      ST_IDLE: begin
        if (run_db && !cpu_halt) begin
          state_n = ST_RUN;
          div_n   = '0;
          en_n    = 1'b1;
        end else if (step_rise) begin
          state_n = ST_STEP;
          en_n    = 1'b1;
        end
      end
      ST_STEP: state_n = ST_WAIT_REL;
      ST_WAIT_REL: begin
        if (!step_db) state_n = ST_IDLE;
      end
      ST_RUN: begin
        if (!run_db || cpu_halt) begin
          state_n = ST_IDLE;
          div_n   = '0;
        end else begin
          div_n = (div == DW'(RUN_DIV - 1)) ? '0 : div + DW'(1);
          en_n  = (div_n == '0);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      cpu_en   <= 1'b0;
      div      <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_n;
      cpu_en   <= en_n;
      div      <= div_n;
      step_cnt <= step_cnt + CNT_W'(cpu_en);
    end
  end

  // push-to-clear wins over a detent in the same cycle
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      dbg_addr <= '0;
    end else if (ctr_rise) begin
      dbg_addr <= '0;
    end else if (a_rise) begin
      dbg_addr <= b_db ? dbg_addr - ADDR_W'(1) : dbg_addr + ADDR_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: per-cycle model compare plus directed checks.
module tb_cpu_step_ctrl;

  localparam int DB = 4;
  localparam int RD = 3;

  logic        CCLK;
  logic        RSTN;
  logic        sw_run, btn_step, rot_a, rot_b, rot_ctr, cpu_halt;
  logic        cpu_en;
  logic [4:0]  dbg_addr;
  logic [15:0] step_cnt;
  logic [1:0]  state_o;

  logic        rst2, b_run, b_step, b_halt, tie0;
  logic        e2;
  logic [4:0]  a2;
  logic [15:0] c2;
  logic [1:0]  s2;

  cpu_step_ctrl #(.DB_CYCLES(DB), .RUN_DIV(RD)) dut (
    .CCLK(CCLK), .RSTN(RSTN), .sw_run(sw_run), .btn_step(btn_step),
    .rot_a(rot_a), .rot_b(rot_b), .rot_ctr(rot_ctr),
    .cpu_halt(cpu_halt), .cpu_en(cpu_en), .dbg_addr(dbg_addr),
    .step_cnt(step_cnt), .state_o(state_o)
  );

  cpu_step_ctrl #(.DB_CYCLES(1), .RUN_DIV(1)) dut2 (
    .CCLK(CCLK), .RSTN(rst2), .sw_run(b_run), .btn_step(b_step),
    .rot_a(tie0), .rot_b(tie0), .rot_ctr(tie0),
    .cpu_halt(b_halt), .cpu_en(e2), .dbg_addr(a2),
    .step_cnt(c2), .state_o(s2)
  );

  initial CCLK = 1'b0;
  always #10 CCLK = ~CCLK;

  int vecs = 0;
  int miss = 0;
  int cyc_n = 0;

  // model: 0 run, 1 step, 2 rot_a, 3 rot_b, 4 rot_ctr
  bit hist [5][DB+2];
  bit dbv  [5];
  bit prv  [5];
  bit rise [5];
  bit raw  [5];
  int m_mode = 0;
  bit m_en = 0;
  int m_addr = 0;
  int m_cnt = 0;
  int m_ph = 0;
  bit nx_en;
  bit stable;

  always @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < DB + 2; j++) hist[i][j] = 1'b0;
        dbv[i] = 1'b0; prv[i] = 1'b0; rise[i] = 1'b0;
      end
      m_mode = 0; m_en = 0; m_addr = 0; m_cnt = 0; m_ph = 0;
    end else begin
      raw = '{sw_run, btn_step, rot_a, rot_b, rot_ctr};
      m_cnt = (m_cnt + int'(m_en)) % 65536;
      nx_en = 1'b0;
      if (m_mode == 0) begin
        if (dbv[0] && !cpu_halt) begin
          m_mode = 3; m_ph = 0; nx_en = 1'b1;
        end else if (rise[1]) begin
          m_mode = 1; nx_en = 1'b1;
        end
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else if (m_mode == 2) begin
        if (!dbv[1]) m_mode = 0;
      end else begin
        if (!dbv[0] || cpu_halt) m_mode = 0;
        else begin
          m_ph = (m_ph + 1) % RD;
          nx_en = (m_ph == 0);
        end
      end
      m_en = nx_en;
      if (rise[4]) m_addr = 0;
      else if (rise[2]) m_addr = dbv[3] ? (m_addr + 31) % 32 : (m_addr + 1) % 32;
      for (int i = 0; i < 5; i++) begin
        rise[i] = dbv[i] & ~prv[i];
        prv[i] = dbv[i];
      end
      // level moves once the synchronized input held DB+1 samples
      for (int i = 0; i < 5; i++) begin
        stable = 1'b1;
        for (int j = 2; j <= DB + 1; j++) if (hist[i][j] != hist[i][1]) stable = 1'b0;
        if (stable) dbv[i] = hist[i][1];
        for (int j = DB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = raw[i];
      end
    end
  end

  always @(negedge CCLK) begin
    cyc_n++;
    if (RSTN) begin
      vecs++;
      if (cpu_en !== m_en || dbg_addr !== 5'(m_addr) ||
          step_cnt !== 16'(m_cnt) || state_o !== 2'(m_mode)) begin
        miss++;
        $display("FAIL model cyc %0d: en %b/%b addr %0d/%0d cnt %0h/%0h st %0d/%0d (got/expected)",
                 cyc_n, cpu_en, m_en, dbg_addr, m_addr, step_cnt, m_cnt, state_o, m_mode);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CCLK);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    cyc(2);
    RSTN = 1'b1;
    cyc(2);
  endtask

  task automatic step2(input logic [15:0] exp, input string nm);
    b_step = 1'b1;
    cyc(8);
    b_step = 1'b0;
    cyc(8);
    chk(nm, c2, exp);
  endtask

  int pulses;
  int first;

  initial begin
    RSTN = 1'b0; sw_run = 0; btn_step = 0; rot_a = 0; rot_b = 0;
    rot_ctr = 0; cpu_halt = 0;
    rst2 = 1'b0; b_run = 0; b_step = 0; b_halt = 0; tie0 = 0;
    cyc(3);
    chk("rst_en", cpu_en, 0);
    chk("rst_state", state_o, 0);
    chk("rst_cnt", step_cnt, 0);
    chk("rst_addr", dbg_addr, 0);
    RSTN = 1'b1;
    cyc(3);

    btn_step = 1'b1;
    pulses = 0; first = -1;
    for (int i = 1; i <= 50; i++) begin
      cyc(1);
      if (cpu_en) begin
        pulses++;
        if (first < 0) first = i - 1;
      end
      if (i == 8) chk("pre_step_state", state_o, 0);
      if (i == 9) chk("step_state", state_o, 1);
      if (i == 10) chk("wait_rel_state", state_o, 2);
    end
    chk("step_pulses", pulses, 1);
    chk("step_latency_edge", first, DB + 4);
    chk("held_state", state_o, 2);
    btn_step = 1'b0;
    cyc(10);
    chk("released_state", state_o, 0);
    chk("step_cnt_one", step_cnt, 1);

    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_step = ((i / 2) % 2) == 0;
      cyc(1);
      pulses += int'(cpu_en);
    end
    btn_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      pulses += int'(cpu_en);
    end
    chk("bounce_pulses", pulses, 0);
    chk("bounce_cnt", step_cnt, 0);
    chk("bounce_state", state_o, 0);

    sw_run = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 37; i++) begin
      cyc(1);
      if (i == 7) chk("run_not_yet", state_o, 0);
      if (i == 8) begin
        chk("run_state", state_o, 3);
        chk("run_first_en", cpu_en, 1);
      end
      if (i >= 8) pulses += int'(cpu_en);
    end
    chk("run_pulses_30", pulses, 10);
    cpu_halt = 1'b1;
    cyc(1);
    chk("halt_state", state_o, 0);
    chk("halt_en", cpu_en, 0);
    btn_step = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      pulses += int'(cpu_en);
    end
    chk("halt_step_pulses", pulses, 1);
    btn_step = 1'b0;
    cyc(10);
    chk("halt_step_idle", state_o, 0);
    chk("run_step_cnt", step_cnt, 11);
    cpu_halt = 1'b0;
    for (int i = 0; i < 10 && !cpu_en; i++) cyc(1);
    chk("run_reentry", cpu_en, 1);
    #5 RSTN = 1'b0;
    #1;
    chk("async_rst_en", cpu_en, 0);
    chk("async_rst_state", state_o, 0);
    chk("async_rst_cnt", step_cnt, 0);
    cyc(2);
    RSTN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (i == 7) chk("held_run_wait", state_o, 0);
      if (i == 8) chk("held_run_fresh", state_o, 3);
    end
    sw_run = 1'b0;
    cyc(10);
    chk("run_off_state", state_o, 0);

    do_reset();
    rot_b = 1'b1;
    cyc(8);
    rot_a = 1'b1;
    cyc(10);
    chk("rot_ccw_wrap", dbg_addr, 31);
    rot_a = 1'b0;
    cyc(8);
    rot_b = 1'b0;
    cyc(8);
    rot_a = 1'b1;
    cyc(10);
    chk("rot_cw_wrap", dbg_addr, 0);
    rot_a = 1'b0;
    cyc(8);
    rot_a = 1'b1;
    cyc(10);
    chk("rot_cw_one", dbg_addr, 1);
    rot_a = 1'b0;
    cyc(8);
    rot_a = 1'b1;
    rot_ctr = 1'b1;
    cyc(10);
    chk("rot_ctr_priority", dbg_addr, 0);
    rot_a = 1'b0;
    rot_ctr = 1'b0;
    cyc(8);

    rst2 = 1'b1;
    cyc(2);
    b_run = 1'b1;
    cyc(100);
    chk("div1_en_high", e2, 1);
    cyc(65438);
    b_halt = 1'b1;
    cyc(3);
    chk("wrap_preload", c2, 16'hFFFE);
    chk("wrap_halt_state", s2, 0);
    step2(16'hFFFF, "wrap_step1");
    step2(16'h0000, "wrap_step2");
    step2(16'h0001, "wrap_step3");
    chk("wrap_en_low", e2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000: consecutive stable cycles required before a debounced input changes.
REQ-002 Parameter RUN_DIV, default 1: in RUN, cpu_en pulses once every RUN_DIV cycles; RUN_DIV>=1.
REQ-003 CCLK  in  1  sole clock, all logic rising-edge.
REQ-004 RSTN  in  1  asynchronous, active-low reset.
REQ-005 sw_run  in  1  raw switch; 1 = free-run, 0 = single-step.
REQ-006 btn_step  in  1  raw step button, active-high.
REQ-007 rot_a, rot_b  in  1 each  raw rotary quadrature phases.
REQ-008 rot_ctr  in  1  raw rotary push; clears dbg_addr.
REQ-009 cpu_halt  in  1  synchronous halt request from the CPU pipeline.
REQ-010 cpu_en  out  1  clock enable to the pipelined CPU; one high cycle = one CPU cycle.
REQ-011 dbg_addr  out  5  register index for the LCD register display.
REQ-012 step_cnt  out  16  count of cpu_en high cycles.
REQ-013 state_o  out  2  current FSM state encoding, for LEDs.

Function
REQ-014 Each raw input (sw_run, btn_step, rot_a, rot_b, rot_ctr) SHALL pass a 2-flop synchronizer and then a debouncer.
REQ-015 Debouncer: counter clears on any synchronized-value change; debounced output takes the new value when the counter reaches DB_CYCLES.
REQ-016 FSM states: IDLE=2'b00, STEP=2'b01, WAIT_REL=2'b10, RUN=2'b11; state_o equals the state register.
REQ-017 IDLE: run_db=1 and cpu_halt=0 -> RUN; otherwise, a step_db rising edge -> STEP; otherwise stay.
REQ-018 STEP: cpu_en=1 for exactly this one cycle; next state WAIT_REL.
REQ-019 WAIT_REL: cpu_en=0; step_db=0 -> IDLE, so a held button yields exactly one step.
REQ-020 RUN divider counts 0..RUN_DIV-1 and wraps; cpu_en=1 when the divider is 0; RUN_DIV=1 gives cpu_en continuously high.
REQ-021 RUN: run_db=0 or cpu_halt=1 -> IDLE; cpu_en is forced 0 in that same cycle; the divider clears on RUN entry.
REQ-022 Single-step in IDLE is allowed regardless of cpu_halt, so stepping past a halt is possible.
REQ-023 step_cnt increments by 1 in every cycle with cpu_en=1 and wraps 16'hFFFF -> 16'h0000.
REQ-024 dbg_addr: on a rot_a_db rising edge, rot_b_db=0 -> +1, rot_b_db=1 -> -1, both modulo 32 (31+1=0, 0-1=31).
REQ-025 A rot_ctr_db rising edge sets dbg_addr=0 and has priority over a rotation step in the same cycle.
REQ-026 Step latency: cpu_en rises exactly DB_CYCLES+4 cycles after the first CCLK edge sampling btn_step=1 (raw input held stable).
REQ-027 cpu_en, dbg_addr, step_cnt and state_o SHALL be registered outputs, with no combinational path from any input.

Reset
REQ-028 RSTN low SHALL asynchronously force state IDLE, cpu_en=0, dbg_addr=0, step_cnt=0, divider=0, and all synchronizer, debounce counter and debounced registers to 0.
REQ-029 Reset asserted mid-STEP or mid-RUN SHALL drop cpu_en in the same cycle, with no further pulse.
REQ-030 After RSTN rises, a switch or button already held high SHALL be treated as a fresh edge after debounce.

Structure
REQ-031 Shared package cpu_step_pkg SHALL hold the state encodings (ST_IDLE, ST_STEP, ST_WAIT_REL, ST_RUN) and the widths ADDR_W=5 and CNT_W=16.
REQ-032 Sub-module btn_debounce (synchronizer + counter, parameter DB_CYCLES) SHALL be instantiated five times; the FSM, divider and rotary decode stay in cpu_step_ctrl.

Verification (DB_CYCLES=4, RUN_DIV=3, 20 ns CCLK)
REQ-033 Reset mid-RUN: RSTN low -> cpu_en=0, state_o=00 and step_cnt=0 in the same cycle, without waiting for a clock edge.
REQ-034 Single step: btn_step held high 50 cycles -> exactly one cpu_en pulse at cycle 8; step_cnt=1; state_o sequence 00,01,10, then 00 after release.
REQ-035 Bounce: btn_step toggles every 2 cycles for 20 cycles, then stays 0 -> no cpu_en pulse, step_cnt=0.
REQ-036 Run and halt: sw_run=1 for 30 cycles after debounce -> cpu_en high every 3rd cycle; cpu_halt=1 -> cpu_en=0 that cycle, state_o=00; a following step still gives one pulse.
REQ-037 Rotary wrap: dbg_addr=0, one CCW detent (rot_b=1 on rot_a rise) -> 31; one CW detent -> 0; rot_ctr with a simultaneous detent -> 0.
REQ-038 Counter wrap: preload to step_cnt=16'hFFFE by 2 steps short, then 3 steps -> step_cnt=16'h0001.
